// File: rtl/regbank_sequencer_if.sv
// Handshake and bank-port bundle for regbank_sequencer.
// master drives requests and bank read data; slave is the sequencer.
interface regbank_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_BITS   = 4
);
  logic                  rdReqValid;
  logic                  rdReqReady;
  logic [REG_BITS-1:0]   rs1;
  logic [REG_BITS-1:0]   rs2;
  logic                  rspValid;
  logic                  rspReady;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;
  logic                  wbValid;
  logic                  wbReady;
  logic [REG_BITS-1:0]   wbReg;
  logic [DATA_WIDTH-1:0] wbData;
  logic [REG_BITS-1:0]   bankRegNum;
  logic [DATA_WIDTH-1:0] bankWrData;
  logic                  bankWe;
  logic [DATA_WIDTH-1:0] bankRdData;
  logic                  busy;

  modport master (
    output rdReqValid, rs1, rs2, rspReady,
    output wbValid, wbReg, wbData, bankRdData,
    input  rdReqReady, rspValid, op1, op2, wbReady,
    input  bankRegNum, bankWrData, bankWe, busy
  );

  modport slave (
    input  rdReqValid, rs1, rs2, rspReady,
    input  wbValid, wbReg, wbData, bankRdData,
    output rdReqReady, rspValid, op1, op2, wbReady,
    output bankRegNum, bankWrData, bankWe, busy
  );
endinterface

// File: rtl/regbank_sequencer.sv
// Serialises rs1/rs2 operand reads and write-backs onto the
// single register bank port; write-back wins over reads in IDLE.
module regbank_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_BITS   = 4
) (
  input logic             clk,
  input logic             reset,
  regbank_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, READ1, READ2, RESP, WRITE
  } state_t;

  state_t                state, state_d;
  logic [REG_BITS-1:0]   rs2_q, rs2_d;
  logic [REG_BITS-1:0]   regnum_q, regnum_d;
  logic [DATA_WIDTH-1:0] wrdata_q, wrdata_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d;
  logic [DATA_WIDTH-1:0] op2_q, op2_d;
  logic                  we_q, we_d;
  logic                  rsp_q, rsp_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rs2_q    <= '0;
      regnum_q <= '0;
      wrdata_q <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      we_q     <= 1'b0;
      rsp_q    <= 1'b0;
    end else begin
      state    <= state_d;
      rs2_q    <= rs2_d;
      regnum_q <= regnum_d;
      wrdata_q <= wrdata_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      we_q     <= we_d;
      rsp_q    <= rsp_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (bus.wbValid)
          state_d = WRITE;
        else if (bus.rdReqValid)
          state_d = READ1;
      end
      WRITE: state_d = IDLE;
      READ1: state_d = READ2;
      READ2: state_d = RESP;
      RESP: begin
        if (bus.rspReady)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are loaded with the values of the state being
  // entered, so the bank port always reflects the current state.
  always_comb begin
    rs2_d    = rs2_q;
    regnum_d = regnum_q;
    wrdata_d = wrdata_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    we_d     = 1'b0;
    rsp_d    = rsp_q;
    unique case (state)
      IDLE: begin
        if (bus.wbValid) begin
          regnum_d = bus.wbReg;
          wrdata_d = bus.wbData;
          we_d     = (bus.wbReg != '0);
        end else if (bus.rdReqValid) begin
          regnum_d = bus.rs1;
          rs2_d    = bus.rs2;
        end
      end
      READ1: begin
        op1_d    = bus.bankRdData;
        regnum_d = rs2_q;
      end
      READ2: begin
        op2_d = bus.bankRdData;
        rsp_d = 1'b1;
      end
      RESP: begin
        if (bus.rspReady)
          rsp_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.rdReqReady = (state == IDLE);
  assign bus.wbReady    = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.rspValid   = rsp_q;
  assign bus.op1        = op1_q;
  assign bus.op2        = op2_q;
  assign bus.bankRegNum = regnum_q;
  assign bus.bankWrData = wrdata_q;
  assign bus.bankWe     = we_q;
endmodule

// File: tb/tb_regbank_sequencer.sv
// Directed bench for regbank_sequencer with a 16-entry
// combinational-read register bank model.
module tb_regbank_sequencer;
  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   cyc;
  int   we_idle;
  int   we_r0;

  regbank_sequencer_if #(
    .DATA_WIDTH(32), .REG_BITS(4)
  ) bus ();

  regbank_sequencer #(
    .DATA_WIDTH(32), .REG_BITS(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  logic [31:0] regs [16] = '{default: 32'h0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.bankWe && bus.bankRegNum != 4'd0)
      regs[bus.bankRegNum] <= bus.bankWrData;
    if (bus.bankWe && !bus.busy)
      we_idle <= we_idle + 1;
    if (bus.bankWe && bus.bankRegNum == 4'd0)
      we_r0 <= we_r0 + 1;
  end

  assign bus.bankRdData =
    (bus.bankRegNum == 4'd0) ? 32'h0 : regs[bus.bankRegNum];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] r,
                          input logic [31:0] d,
                          input string nm);
    bus.wbReg   = r;
    bus.wbData  = d;
    bus.wbValid = 1'b1;
    for (int i = 0; i < 20 && !bus.wbReady; i++) tick();
    checks++;
    if (bus.wbReady !== 1'b1) begin
      failures++;
      $display("FAIL %s_wait wbReady=%b want 1", nm, bus.wbReady);
    end
    tick();
    bus.wbValid = 1'b0;
    checks++;
    if (bus.bankWe !== (r != 4'd0) || bus.bankRegNum !== r ||
        bus.bankWrData !== d || bus.wbReady !== 1'b0 ||
        bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_wr we=%b num=%0d data=%h rdy=%b busy=%b want we=%b num=%0d data=%h rdy=0 busy=1",
               nm, bus.bankWe, bus.bankRegNum, bus.bankWrData,
               bus.wbReady, bus.busy, (r != 4'd0), r, d);
    end
    tick();
    checks++;
    if (bus.bankWe !== 1'b0 || bus.wbReady !== 1'b1 ||
        bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_done we=%b rdy=%b busy=%b want 0 1 0",
               nm, bus.bankWe, bus.wbReady, bus.busy);
    end
  endtask

  task automatic do_read(input logic [3:0] a,
                         input logic [3:0] b,
                         input logic [31:0] e1,
                         input logic [31:0] e2,
                         input int stall,
                         input string nm);
    bus.rs1        = a;
    bus.rs2        = b;
    bus.rdReqValid = 1'b1;
    bus.rspReady   = (stall == 0);
    for (int i = 0; i < 20 && !bus.rdReqReady; i++) tick();
    checks++;
    if (bus.rdReqReady !== 1'b1) begin
      failures++;
      $display("FAIL %s_wait rdReqReady=%b want 1", nm, bus.rdReqReady);
    end
    tick();
    bus.rdReqValid = 1'b0;
    checks++;
    if (bus.bankRegNum !== a || bus.bankWe !== 1'b0 ||
        bus.rspValid !== 1'b0) begin
      failures++;
      $display("FAIL %s_rd1 num=%0d we=%b rv=%b want num=%0d we=0 rv=0",
               nm, bus.bankRegNum, bus.bankWe, bus.rspValid, a);
    end
    tick();
    checks++;
    if (bus.bankRegNum !== b || bus.rspValid !== 1'b0) begin
      failures++;
      $display("FAIL %s_rd2 num=%0d rv=%b want num=%0d rv=0",
               nm, bus.bankRegNum, bus.rspValid, b);
    end
    tick();
    checks++;
    if (bus.rspValid !== 1'b1 || bus.op1 !== e1 || bus.op2 !== e2) begin
      failures++;
      $display("FAIL %s_rsp rv=%b op1=%h op2=%h want 1 %h %h",
               nm, bus.rspValid, bus.op1, bus.op2, e1, e2);
    end
    for (int s = 0; s < stall; s++) begin
      tick();
      checks++;
      if (bus.rspValid !== 1'b1 || bus.op1 !== e1 ||
          bus.op2 !== e2 || bus.rdReqReady !== 1'b0 ||
          bus.bankWe !== 1'b0) begin
        failures++;
        $display("FAIL %s_stall%0d rv=%b op1=%h op2=%h rdy=%b we=%b want 1 %h %h 0 0",
                 nm, s, bus.rspValid, bus.op1, bus.op2,
                 bus.rdReqReady, bus.bankWe, e1, e2);
      end
    end
    bus.rspReady = 1'b1;
    tick();
    bus.rspReady = 1'b0;
    checks++;
    if (bus.rspValid !== 1'b0 || bus.rdReqReady !== 1'b1) begin
      failures++;
      $display("FAIL %s_hs rv=%b rdy=%b want 0 1",
               nm, bus.rspValid, bus.rdReqReady);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.rspValid !== 1'b0 || bus.bankWe !== 1'b0 ||
        bus.bankRegNum !== 4'd0 || bus.bankWrData !== 32'h0 ||
        bus.op1 !== 32'h0 || bus.op2 !== 32'h0 ||
        bus.busy !== 1'b0 || bus.rdReqReady !== 1'b1 ||
        bus.wbReady !== 1'b1) begin
      failures++;
      $display("FAIL reset rv=%b we=%b num=%0d wd=%h op1=%h op2=%h busy=%b rr=%b wr=%b want all 0 ready 1",
               bus.rspValid, bus.bankWe, bus.bankRegNum,
               bus.bankWrData, bus.op1, bus.op2, bus.busy,
               bus.rdReqReady, bus.wbReady);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    do_write(4'd5, 32'hDEADBEEF, "wr5");
    checks++;
    if (regs[5] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL bank_r5 got %h want deadbeef", regs[5]);
    end
    do_read(4'd5, 4'd0, 32'hDEADBEEF, 32'h0, 0, "rd50");
  endtask

  task automatic test_raw();
    bus.wbReg      = 4'd3;
    bus.wbData     = 32'h12345678;
    bus.wbValid    = 1'b1;
    bus.rs1        = 4'd3;
    bus.rs2        = 4'd3;
    bus.rdReqValid = 1'b1;
    tick();
    bus.wbValid = 1'b0;
    checks++;
    if (bus.bankWe !== 1'b1 || bus.bankRegNum !== 4'd3 ||
        bus.rdReqReady !== 1'b0) begin
      failures++;
      $display("FAIL raw_wfirst we=%b num=%0d rr=%b want 1 3 0",
               bus.bankWe, bus.bankRegNum, bus.rdReqReady);
    end
    tick();
    checks++;
    if (bus.rdReqReady !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL raw_idle rr=%b busy=%b want 1 0",
               bus.rdReqReady, bus.busy);
    end
    do_read(4'd3, 4'd3, 32'h12345678, 32'h12345678, 0, "raw");
  endtask

  task automatic test_r0();
    do_write(4'd0, 32'hFFFFFFFF, "wr0");
    do_read(4'd0, 4'd0, 32'h0, 32'h0, 0, "rd00");
  endtask

  task automatic test_stall();
    do_write(4'd9, 32'hCAFEF00D, "wr9");
    do_read(4'd9, 4'd5, 32'hCAFEF00D, 32'hDEADBEEF, 5, "stall");
  endtask

  task automatic test_reset_mid();
    do_write(4'd7, 32'hA5A5A5A5, "wr7");
    bus.rs1        = 4'd7;
    bus.rs2        = 4'd7;
    bus.rdReqValid = 1'b1;
    tick();
    bus.rdReqValid = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.rspValid !== 1'b0 || bus.bankWe !== 1'b0 ||
        bus.bankRegNum !== 4'd0 || bus.op1 !== 32'h0 ||
        bus.busy !== 1'b0 || bus.rdReqReady !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset rv=%b we=%b num=%0d op1=%h busy=%b rr=%b want 0 0 0 0 0 1",
               bus.rspValid, bus.bankWe, bus.bankRegNum,
               bus.op1, bus.busy, bus.rdReqReady);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    do_read(4'd7, 4'd5, 32'hA5A5A5A5, 32'hDEADBEEF, 0, "post");
  endtask

  task automatic test_back_to_back();
    logic [3:0]  a [3];
    logic [3:0]  b [3];
    logic [31:0] v [16];
    int          last;
    a = '{4'd1, 4'd2, 4'd5};
    b = '{4'd2, 4'd1, 4'd3};
    do_write(4'd1, 32'h11111111, "wr1");
    do_write(4'd2, 32'h22222222, "wr2");
    v = regs;
    last = 0;
    bus.rspReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.rs1        = a[k];
      bus.rs2        = b[k];
      bus.rdReqValid = 1'b1;
      for (int i = 0; i < 20 && !bus.rdReqReady; i++) tick();
      tick();
      if (k > 0) begin
        checks++;
        if (cyc - last !== 4) begin
          failures++;
          $display("FAIL b2b_gap%0d got %0d want 4", k, cyc - last);
        end
      end
      last = cyc;
      checks++;
      if (bus.bankRegNum !== a[k]) begin
        failures++;
        $display("FAIL b2b_rs1_%0d got %0d want %0d",
                 k, bus.bankRegNum, a[k]);
      end
      tick();
      checks++;
      if (bus.bankRegNum !== b[k]) begin
        failures++;
        $display("FAIL b2b_rs2_%0d got %0d want %0d",
                 k, bus.bankRegNum, b[k]);
      end
      tick();
      checks++;
      if (bus.rspValid !== 1'b1 || bus.op1 !== v[a[k]] ||
          bus.op2 !== v[b[k]]) begin
        failures++;
        $display("FAIL b2b_rsp%0d rv=%b op1=%h op2=%h want 1 %h %h",
                 k, bus.rspValid, bus.op1, bus.op2,
                 v[a[k]], v[b[k]]);
      end
      if (k == 2) bus.rdReqValid = 1'b0;
      tick();
    end
    bus.rspReady = 1'b0;
    checks++;
    if (bus.rspValid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end rv=%b busy=%b want 0 0",
               bus.rspValid, bus.busy);
    end
  endtask

  task automatic test_we_monitor();
    checks++;
    if (we_idle !== 0 || we_r0 !== 0) begin
      failures++;
      $display("FAIL we_monitor idle_we=%0d r0_we=%0d want 0 0",
               we_idle, we_r0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks         = 0;
    failures       = 0;
    cyc            = 0;
    we_idle        = 0;
    we_r0          = 0;
    reset          = 1'b0;
    bus.rdReqValid = 1'b0;
    bus.rs1        = '0;
    bus.rs2        = '0;
    bus.rspReady   = 1'b0;
    bus.wbValid    = 1'b0;
    bus.wbReg      = '0;
    bus.wbData     = '0;
    test_reset();
    test_write_read();
    test_raw();
    test_r0();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_we_monitor();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
